player_hit_judge: RTL and testbench

//  Enemy-to-player collision judge, the counterpart of the enemy-side boom check.
//  - Compares one enemy bullet box with the player plane box every clk.
//  - On a hit it clears the bullet, takes one life and starts a blinking

---
 rtl/plane_pkg.sv | 16 +
 rtl/rect_overlap.sv | 30 +++
 rtl/player_hit_judge.sv | 137 +++++++++++++
 tb/tb_player_hit_judge.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/plane_pkg.sv
// Shared sprite geometry and player-judge state encoding.
package plane_pkg;

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned PLANE_W  = 50;
    localparam int unsigned PLANE_H  = 50;
    localparam int unsigned BULLET_W = 10;
    localparam int unsigned BULLET_H = 10;

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DEAD   = 2'd2
    } judge_state_t;

endpackage

// File: rtl/rect_overlap.sv
// Combinational axis-aligned box overlap test with half-open edges.
//   a_x/a_y : top-left of box A (size A_W x A_H)
//   b_x/b_y : top-left of box B (size B_W x B_H)
//   hit     : 1 when the boxes share at least one pixel
module rect_overlap
    import plane_pkg::*;
#(
    parameter int unsigned A_W = 50,
    parameter int unsigned A_H = 50,
    parameter int unsigned B_W = 10,
    parameter int unsigned B_H = 10
) (
    input  logic [COORD_W-1:0] a_x,
    input  logic [COORD_W-1:0] a_y,
    input  logic [COORD_W-1:0] b_x,
    input  logic [COORD_W-1:0] b_y,
    output logic               hit
);

    // One extra bit so coordinate + size never wraps.
    localparam int unsigned CW = COORD_W + 1;

    logic ov_x;
    logic ov_y;

    assign ov_x = (CW'(b_x) + CW'(B_W) > CW'(a_x)) && (CW'(b_x) < CW'(a_x) + CW'(A_W));
    assign ov_y = (CW'(b_y) + CW'(B_H) > CW'(a_y)) && (CW'(b_y) < CW'(a_y) + CW'(A_H));
    assign hit  = ov_x && ov_y;

endmodule

// File: rtl/player_hit_judge.sv
// Enemy-bullet vs player collision judge with lives, invulnerability
// window and blink flag for the sprite mux.
//   clk, rst       : clock, asynchronous active-high reset
//   pp_x, pp_y     : player plane top-left
//   eb_x, eb_y     : enemy bullet top-left, eb_valid marks it present
//   restart        : reload lives and return to ALIVE
//   eb_consume     : pulse, bullet owner clears its bullet
//   hit_pulse      : pulse per damaging hit
//   lives          : remaining lives
//   invuln, blink  : invulnerability window and sprite-visible flag
//   game_over      : high while DEAD
module player_hit_judge
    import plane_pkg::*;
#(
    parameter int unsigned PLANE_W       = plane_pkg::PLANE_W,
    parameter int unsigned PLANE_H       = plane_pkg::PLANE_H,
    parameter int unsigned BULLET_W      = plane_pkg::BULLET_W,
    parameter int unsigned BULLET_H      = plane_pkg::BULLET_H,
    parameter int unsigned INIT_LIVES    = 3,
    parameter int unsigned INVULN_CYCLES = 750000,
    parameter int unsigned BLINK_HALF    = 62500
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] pp_x,
    input  logic [COORD_W-1:0] pp_y,
    input  logic [COORD_W-1:0] eb_x,
    input  logic [COORD_W-1:0] eb_y,
    input  logic               eb_valid,
    input  logic               restart,
    output logic               eb_consume,
    output logic               hit_pulse,
    output logic [2:0]         lives,
    output logic               invuln,
    output logic               blink,
    output logic               game_over
);

    localparam int unsigned INV_CNT_W   = 20;
    localparam int unsigned BLINK_CNT_W = 17;
    localparam logic [INV_CNT_W-1:0]   INV_LAST   = INV_CNT_W'(INVULN_CYCLES - 1);
    localparam logic [BLINK_CNT_W-1:0] BLINK_LAST = BLINK_CNT_W'(BLINK_HALF - 1);
    localparam logic [2:0]             LIVES_INIT = 3'(INIT_LIVES);

    judge_state_t           state;
    logic [INV_CNT_W-1:0]   inv_cnt;
    logic [BLINK_CNT_W-1:0] blink_cnt;
    logic                   box_hit;
    logic                   overlap;

    rect_overlap #(
        .A_W (PLANE_W),
        .A_H (PLANE_H),
        .B_W (BULLET_W),
        .B_H (BULLET_H)
    ) u_overlap (
        .a_x (pp_x),
        .a_y (pp_y),
        .b_x (eb_x),
        .b_y (eb_y),
        .hit (box_hit)
    );

    assign overlap = eb_valid && box_hit;

    // Judge FSM; invuln/game_over are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_ALIVE;
            lives      <= LIVES_INIT;
            inv_cnt    <= '0;
            blink_cnt  <= '0;
            blink      <= 1'b1;
            invuln     <= 1'b0;
            game_over  <= 1'b0;
            eb_consume <= 1'b0;
            hit_pulse  <= 1'b0;
        end else begin
            eb_consume <= 1'b0;
            hit_pulse  <= 1'b0;
            if (restart) begin
                // Restart wins over any same-cycle overlap.
                state     <= ST_ALIVE;
                lives     <= LIVES_INIT;
                inv_cnt   <= '0;
                blink_cnt <= '0;
                blink     <= 1'b1;
                invuln    <= 1'b0;
                game_over <= 1'b0;
            end else begin
                case (state)
                    ST_ALIVE: begin
                        if (overlap && (lives != 3'd0)) begin
                            eb_consume <= 1'b1;
                            hit_pulse  <= 1'b1;
                            lives      <= lives - 3'd1;
                            if (lives == 3'd1) begin
                                state     <= ST_DEAD;
                                game_over <= 1'b1;
                            end else begin
                                state     <= ST_INVULN;
                                invuln    <= 1'b1;
                                inv_cnt   <= '0;
                                blink_cnt <= '0;
                                blink     <= 1'b0;
                            end
                        end
                    end
                    ST_INVULN: begin
                        if (inv_cnt == INV_LAST) begin
                            state     <= ST_ALIVE;
                            invuln    <= 1'b0;
                            inv_cnt   <= '0;
                            blink_cnt <= '0;
                            blink     <= 1'b1;
                        end else begin
                            inv_cnt <= inv_cnt + INV_CNT_W'(1);
                            if (blink_cnt == BLINK_LAST) begin
                                blink_cnt <= '0;
                                blink     <= ~blink;
                            end else begin
                                blink_cnt <= blink_cnt + BLINK_CNT_W'(1);
                            end
                        end
                    end
                    ST_DEAD: begin
                        lives <= 3'd0;
                    end
                    default: begin
                        state <= ST_ALIVE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_player_hit_judge.sv
module tb_player_hit_judge;

    localparam int unsigned INV_N = 20;
    localparam int unsigned BH    = 4;

    typedef struct packed {
        logic       consume;
        logic       hit;
        logic [2:0] lives;
        logic       invuln;
        logic       blink;
        logic       game_over;
    } exp_t;

    typedef struct {
        logic [9:0] px;
        logic [9:0] py;
        logic [9:0] ex;
        logic [9:0] ey;
        logic       v;
        logic       hit;
    } vec_t;

    localparam exp_t RST_EXP = '{consume: 1'b0, hit: 1'b0, lives: 3'd3,
                                 invuln: 1'b0, blink: 1'b1, game_over: 1'b0};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] pp_x = '0, pp_y = '0, eb_x = '0, eb_y = '0;
    logic       eb_valid = 1'b0;
    logic       restart = 1'b0;
    logic       eb_consume, hit_pulse, invuln, blink, game_over;
    logic [2:0] lives;

    int errors = 0;
    int checks = 0;

    exp_t sb_q[$];

    // Reference model state
    int m_state = 0; // 0 alive, 1 invuln, 2 dead
    int m_lives = 3;
    int m_t     = 0;

    always #5 clk = ~clk;

    player_hit_judge #(
        .INIT_LIVES    (3),
        .INVULN_CYCLES (INV_N),
        .BLINK_HALF    (BH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pp_x       (pp_x),
        .pp_y       (pp_y),
        .eb_x       (eb_x),
        .eb_y       (eb_y),
        .eb_valid   (eb_valid),
        .restart    (restart),
        .eb_consume (eb_consume),
        .hit_pulse  (hit_pulse),
        .lives      (lives),
        .invuln     (invuln),
        .blink      (blink),
        .game_over  (game_over)
    );

    function automatic exp_t dut_out();
        exp_t a;
        a = '{consume: eb_consume, hit: hit_pulse, lives: lives,
              invuln: invuln, blink: blink, game_over: game_over};
        return a;
    endfunction

    task automatic check(input string name, input exp_t exp);
        exp_t act;
        act = dut_out();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got {cons=%b hit=%b lives=%0d inv=%b blink=%b go=%b} want {cons=%b hit=%b lives=%0d inv=%b blink=%b go=%b}",
                     name, $time, act.consume, act.hit, act.lives, act.invuln, act.blink, act.game_over,
                     exp.consume, exp.hit, exp.lives, exp.invuln, exp.blink, exp.game_over);
        end
    endtask

    function automatic logic model_ov();
        int ex, ey, px, py;
        ex = int'(eb_x); ey = int'(eb_y); px = int'(pp_x); py = int'(pp_y);
        return eb_valid && (ex + 10 > px) && (ex < px + 50) && (ey + 10 > py) && (ey < py + 50);
    endfunction

    task automatic model_reset();
        m_state = 0; m_lives = 3; m_t = 0;
    endtask

    // Expected outputs one cycle after the currently driven inputs.
    task automatic model_next(output exp_t e);
        logic ov;
        ov = model_ov();
        e = '0;
        if (restart) begin
            model_reset();
        end else if (m_state == 0) begin
            if (ov) begin
                e.consume = 1'b1;
                e.hit     = 1'b1;
                m_lives   = m_lives - 1;
                if (m_lives == 0) m_state = 2;
                else begin m_state = 1; m_t = 0; end
            end
        end else if (m_state == 1) begin
            if (m_t == INV_N - 1) m_state = 0;
            else m_t = m_t + 1;
        end
        e.lives     = 3'(m_lives);
        e.invuln    = (m_state == 1);
        e.game_over = (m_state == 2);
        e.blink     = (m_state == 1) ? (((m_t / BH) % 2) == 1) : 1'b1;
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            check(name, e);
        end
    endtask

    // Model-driven cycle: push expectation, clock, compare.
    task automatic tick(input string name);
        exp_t e;
        model_next(e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        pop_check(name);
    endtask

    // Table-driven cycle with an explicit expectation.
    task automatic tick_exp(input string name, input exp_t e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        pop_check(name);
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        restart = 1'b0;
        eb_valid = 1'b0;
        #1;
        check(name, RST_EXP);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic set_hit_pos();
        pp_x = 10'd100; pp_y = 10'd400;
        eb_x = 10'd120; eb_y = 10'd410;
        eb_valid = 1'b1;
    endtask

    vec_t vecs[11];

    initial begin
        exp_t e_hit, e_miss;

        vecs[0]  = '{px: 10'd100,  py: 10'd400,  ex: 10'd120,  ey: 10'd410,  v: 1'b1, hit: 1'b1};
        vecs[1]  = '{px: 10'd100,  py: 10'd400,  ex: 10'd90,   ey: 10'd410,  v: 1'b1, hit: 1'b0};
        vecs[2]  = '{px: 10'd100,  py: 10'd400,  ex: 10'd91,   ey: 10'd410,  v: 1'b1, hit: 1'b1};
        vecs[3]  = '{px: 10'd100,  py: 10'd400,  ex: 10'd150,  ey: 10'd410,  v: 1'b1, hit: 1'b0};
        vecs[4]  = '{px: 10'd100,  py: 10'd400,  ex: 10'd149,  ey: 10'd410,  v: 1'b1, hit: 1'b1};
        vecs[5]  = '{px: 10'd100,  py: 10'd400,  ex: 10'd120,  ey: 10'd390,  v: 1'b1, hit: 1'b0};
        vecs[6]  = '{px: 10'd100,  py: 10'd400,  ex: 10'd120,  ey: 10'd391,  v: 1'b1, hit: 1'b1};
        vecs[7]  = '{px: 10'd100,  py: 10'd400,  ex: 10'd120,  ey: 10'd450,  v: 1'b1, hit: 1'b0};
        vecs[8]  = '{px: 10'd100,  py: 10'd400,  ex: 10'd120,  ey: 10'd410,  v: 1'b0, hit: 1'b0};
        vecs[9]  = '{px: 10'd1000, py: 10'd1000, ex: 10'd1020, ey: 10'd1020, v: 1'b1, hit: 1'b1};
        vecs[10] = '{px: 10'd0,    py: 10'd0,    ex: 10'd0,    ey: 10'd0,    v: 1'b1, hit: 1'b1};

        e_hit  = '{consume: 1'b1, hit: 1'b1, lives: 3'd2, invuln: 1'b1, blink: 1'b0, game_over: 1'b0};
        e_miss = RST_EXP;

        #2;
        do_reset("reset_initial");

        // Overlap geometry, each vector from a fresh reset.
        for (int i = 0; i < 11; i++) begin
            do_reset($sformatf("reset_vec%0d", i));
            pp_x = vecs[i].px; pp_y = vecs[i].py;
            eb_x = vecs[i].ex; eb_y = vecs[i].ey;
            eb_valid = vecs[i].v;
            tick_exp($sformatf("vec%0d", i), vecs[i].hit ? e_hit : e_miss);
            eb_valid = 1'b0;
        end

        // Bullet held through two invuln windows and into DEAD.
        do_reset("reset_seqA");
        set_hit_pos();
        for (int i = 0; i < 60; i++) tick($sformatf("seqA_%0d", i));

        // Restart from DEAD, then restart against a same-cycle overlap.
        restart = 1'b1;
        tick("restart_dead");
        tick("restart_vs_overlap");
        restart = 1'b0;
        eb_valid = 1'b0;
        tick("idle_after_restart");

        // Async reset in the middle of an invuln window.
        set_hit_pos();
        tick("seqC_hit");
        for (int i = 0; i < 5; i++) tick($sformatf("seqC_inv%0d", i));
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_invuln", RST_EXP);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick("hit_after_rst");
        eb_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick($sformatf("post_rst_inv%0d", i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
